// File: rtl/axis_msg_traffic_gen.sv
// axis_msg_traffic_gen: framed AXI-Stream message generator for link bring-up.
// Each message is a header word {RX_UID, TX_UID, LEN_BYTES} followed by
// LEN_BYTES/4 payload words, with TLAST on the last payload word.
//
// Ports:
//   clk_200MHz, peripheral_reset (async, active-high)
//   start/stop, num_msgs, payload_words, tx_uid, rx_uid_base,
//   pattern_mode, gap_cycles                      run configuration
//   m_axis_tdata/tlast/tvalid/tready              generated stream
//   busy, done, msgs_sent                         run status
//   s_axis_*, rx_msgs, rx_err, rx_err_cnt         receive-side checker
//
// Optional feature macro: TRAFGEN_CHECKER_EN adds the receive-side checker
// and its ports. Without it the block is generator-only with the same
// generator cycle behaviour.

module axis_msg_traffic_gen #(
   parameter int          PAYLOAD_MAX_WORDS = 216,
   parameter int          NUM_DEST          = 4,
   parameter logic [31:0] CONST_WORD        = 32'h00000001
) (
   input  logic        clk_200MHz,
   input  logic        peripheral_reset,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] num_msgs,
   input  logic [13:0] payload_words,
   input  logic [7:0]  tx_uid,
   input  logic [7:0]  rx_uid_base,
   input  logic        pattern_mode,
   input  logic [15:0] gap_cycles,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        busy,
   output logic        done,
   output logic [15:0] msgs_sent
`ifdef TRAFGEN_CHECKER_EN
   ,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [15:0] rx_msgs,
   output logic        rx_err,
   output logic [15:0] rx_err_cnt
`endif
);

   localparam logic [13:0] MAX_WORDS = 14'(PAYLOAD_MAX_WORDS);
   localparam logic [7:0]  DEST_LAST = 8'(NUM_DEST - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_GAP
   } state_t;

   function automatic logic [13:0] clip_words(input logic [13:0] w);
      logic [13:0] r;
      if (w == 14'd0) begin
         r = 14'd1;
      end else if (w > MAX_WORDS) begin
         r = MAX_WORDS;
      end else begin
         r = w;
      end
      return r;
   endfunction

   function automatic logic [31:0] hdr_word(
      input logic [7:0]  base,
      input logic [7:0]  tx,
      input logic [13:0] w,
      input logic [7:0]  idx
   );
      logic [7:0] uid;
      uid = base + idx;
      return {uid, tx, w, 2'b00};
   endfunction

   function automatic logic [31:0] pat_word(
      input logic        mode,
      input logic [31:0] cnt
   );
      return mode ? cnt : CONST_WORD;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] tdata_q, tdata_d;
   logic        tlast_q, tlast_d;
   logic        tvalid_q, tvalid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] msgs_q, msgs_d;
   logic [7:0]  dest_q, dest_d;
   logic [31:0] pat_q, pat_d;
   logic [13:0] wcnt_q, wcnt_d;
   logic [15:0] gcnt_q, gcnt_d;
   logic        stop_q, stop_d;
   logic [15:0] num_cfg_q, num_cfg_d;
   logic [13:0] words_cfg_q, words_cfg_d;
   logic [7:0]  tx_cfg_q, tx_cfg_d;
   logic [7:0]  base_cfg_q, base_cfg_d;
   logic        mode_cfg_q, mode_cfg_d;
   logic [15:0] gap_cfg_q, gap_cfg_d;

   logic        stop_seen;
   logic [15:0] msgs_inc;
   logic [7:0]  dest_next;
   logic [13:0] wcnt_inc;
   logic [31:0] pat_inc;

   always_comb begin
      stop_seen = stop_q | stop;
      msgs_inc  = msgs_q + 16'd1;
      dest_next = (dest_q == DEST_LAST) ? 8'd0 : dest_q + 8'd1;
      wcnt_inc  = wcnt_q + 14'd1;
      pat_inc   = pat_q + 32'd1;

      state_d     = state_q;
      tdata_d     = tdata_q;
      tlast_d     = tlast_q;
      tvalid_d    = tvalid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      msgs_d      = msgs_q;
      dest_d      = dest_q;
      pat_d       = pat_q;
      wcnt_d      = wcnt_q;
      gcnt_d      = gcnt_q;
      stop_d      = stop_q;
      num_cfg_d   = num_cfg_q;
      words_cfg_d = words_cfg_q;
      tx_cfg_d    = tx_cfg_q;
      base_cfg_d  = base_cfg_q;
      mode_cfg_d  = mode_cfg_q;
      gap_cfg_d   = gap_cfg_q;

      unique case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            if (start) begin
               num_cfg_d   = num_msgs;
               words_cfg_d = clip_words(payload_words);
               tx_cfg_d    = tx_uid;
               base_cfg_d  = rx_uid_base;
               mode_cfg_d  = pattern_mode;
               gap_cfg_d   = gap_cycles;
               msgs_d      = 16'd0;
               dest_d      = 8'd0;
               pat_d       = 32'd0;
               busy_d      = 1'b1;
               tvalid_d    = 1'b1;
               tlast_d     = 1'b0;
               tdata_d     = hdr_word(rx_uid_base, tx_uid,
                                      clip_words(payload_words), 8'd0);
               state_d     = ST_HDR;
            end
         end

         ST_HDR: begin
            if (stop) begin
               stop_d = 1'b1;
            end
            if (m_axis_tready) begin
               wcnt_d  = 14'd1;
               tdata_d = pat_word(mode_cfg_q, pat_q);
               tlast_d = (words_cfg_q == 14'd1);
               state_d = ST_PAYLOAD;
            end
         end

         ST_PAYLOAD: begin
            if (stop) begin
               stop_d = 1'b1;
            end
            if (m_axis_tready) begin
               pat_d = pat_inc;
               if (tlast_q) begin
                  if (msgs_q != 16'hFFFF) begin
                     msgs_d = msgs_inc;
                  end
                  dest_d = dest_next;
                  if (stop_seen ||
                      (num_cfg_q != 16'd0 && msgs_inc == num_cfg_q)) begin
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                     tdata_d  = 32'd0;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     state_d  = ST_IDLE;
                  end else if (gap_cfg_q != 16'd0) begin
                     // counter reaches zero on the last idle cycle
                     gcnt_d   = gap_cfg_q - 16'd1;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                     tdata_d  = 32'd0;
                     state_d  = ST_GAP;
                  end else begin
                     tvalid_d = 1'b1;
                     tlast_d  = 1'b0;
                     tdata_d  = hdr_word(base_cfg_q, tx_cfg_q,
                                         words_cfg_q, dest_next);
                     state_d  = ST_HDR;
                  end
               end else begin
                  wcnt_d  = wcnt_inc;
                  tdata_d = pat_word(mode_cfg_q, pat_inc);
                  tlast_d = (wcnt_inc == words_cfg_q);
               end
            end
         end

         ST_GAP: begin
            if (stop_seen) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (gcnt_q == 16'd0) begin
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               tdata_d  = hdr_word(base_cfg_q, tx_cfg_q,
                                   words_cfg_q, dest_q);
               state_d  = ST_HDR;
            end else begin
               gcnt_d = gcnt_q - 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_200MHz or posedge peripheral_reset) begin
      if (peripheral_reset) begin
         state_q     <= ST_IDLE;
         tdata_q     <= 32'd0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         msgs_q      <= 16'd0;
         dest_q      <= 8'd0;
         pat_q       <= 32'd0;
         wcnt_q      <= 14'd0;
         gcnt_q      <= 16'd0;
         stop_q      <= 1'b0;
         num_cfg_q   <= 16'd0;
         words_cfg_q <= 14'd1;
         tx_cfg_q    <= 8'd0;
         base_cfg_q  <= 8'd0;
         mode_cfg_q  <= 1'b0;
         gap_cfg_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
         tvalid_q    <= tvalid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         msgs_q      <= msgs_d;
         dest_q      <= dest_d;
         pat_q       <= pat_d;
         wcnt_q      <= wcnt_d;
         gcnt_q      <= gcnt_d;
         stop_q      <= stop_d;
         num_cfg_q   <= num_cfg_d;
         words_cfg_q <= words_cfg_d;
         tx_cfg_q    <= tx_cfg_d;
         base_cfg_q  <= base_cfg_d;
         mode_cfg_q  <= mode_cfg_d;
         gap_cfg_q   <= gap_cfg_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign msgs_sent     = msgs_q;

`ifdef TRAFGEN_CHECKER_EN
   logic        rdy_q, rdy_d;
   logic        in_msg_q, in_msg_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] rx_msgs_q, rx_msgs_d;
   logic        rx_err_q, rx_err_d;
   logic [15:0] rx_err_cnt_q, rx_err_cnt_d;

   logic        beat;
   logic        msg_end;
   logic        bad;
   logic [15:0] cnt_inc;
   logic        unused_hdr_bits;

   // UID fields of the returned header are not checked
   assign unused_hdr_bits = ^s_axis_tdata[31:16];

   always_comb begin
      beat    = s_axis_tvalid & rdy_q;
      msg_end = 1'b0;
      bad     = 1'b0;
      cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

      rdy_d        = 1'b1;
      in_msg_d     = in_msg_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      rx_msgs_d    = rx_msgs_q;
      rx_err_d     = rx_err_q;
      rx_err_cnt_d = rx_err_cnt_q;

      if (beat) begin
         if (!in_msg_q) begin
            len_d = s_axis_tdata[15:0];
            cnt_d = 16'd0;
            if (s_axis_tlast) begin
               msg_end = 1'b1;
               bad     = (s_axis_tdata[15:0] != 16'd0);
            end else begin
               in_msg_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_inc;
            if (s_axis_tlast) begin
               in_msg_d = 1'b0;
               msg_end  = 1'b1;
               bad      = ({cnt_inc, 2'b00} != {2'b00, len_q});
            end
         end
      end

      if (msg_end && rx_msgs_q != 16'hFFFF) begin
         rx_msgs_d = rx_msgs_q + 16'd1;
      end
      if (bad) begin
         rx_err_d = 1'b1;
         if (rx_err_cnt_q != 16'hFFFF) begin
            rx_err_cnt_d = rx_err_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_200MHz or posedge peripheral_reset) begin
      if (peripheral_reset) begin
         rdy_q        <= 1'b0;
         in_msg_q     <= 1'b0;
         len_q        <= 16'd0;
         cnt_q        <= 16'd0;
         rx_msgs_q    <= 16'd0;
         rx_err_q     <= 1'b0;
         rx_err_cnt_q <= 16'd0;
      end else begin
         rdy_q        <= rdy_d;
         in_msg_q     <= in_msg_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         rx_msgs_q    <= rx_msgs_d;
         rx_err_q     <= rx_err_d;
         rx_err_cnt_q <= rx_err_cnt_d;
      end
   end

   assign s_axis_tready = rdy_q;
   assign rx_msgs       = rx_msgs_q;
   assign rx_err        = rx_err_q;
   assign rx_err_cnt    = rx_err_cnt_q;
`endif

endmodule

// File: doc/axis_msg_traffic_gen.md
# axis_msg_traffic_gen

Parametrised AXI-Stream message traffic generator for Aurora link bring-up and throughput runs. It emits framed messages: one header word {RX_UID, TX_UID, LEN_BYTES} followed by LEN_BYTES/4 payload words, with TLAST on the final payload word. It adds configurable message count, round-robin destinations, a payload pattern and inter-message gaps. It sits in front of the driver's input stream, and an optional receive-side checker validates the returned stream.

## Interface
- PAYLOAD_MAX_WORDS, 216: upper clip for payload words per message (≤16383).
- NUM_DEST, 4: number of destination UIDs cycled round-robin (1..256).
- CONST_WORD, 32'h00000001: payload word when pattern_mode=0.
- clk_200MHz  in  1  sole clock.
- peripheral_reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  end run after the current message.
- num_msgs  in  16  messages per run; 0 = continuous until stop.
- payload_words  in  14  payload words per message.
- tx_uid  in  8  TX_UID header field.
- rx_uid_base  in  8  first destination UID.
- pattern_mode  in  1  0 = CONST_WORD, 1 = incrementing counter.
- gap_cycles  in  16  idle cycles between messages.
- m_axis_tdata  out  32;  m_axis_tlast  out  1;  m_axis_tvalid  out  1;  m_axis_tready  in  1.
- busy  out  1  run active.
- done  out  1  one-cycle pulse at run end.
- msgs_sent  out  16  messages fully handshaken this run.
- Checker ports (TRAFGEN_CHECKER_EN only): s_axis_tdata in 32, s_axis_tlast in 1, s_axis_tvalid in 1, s_axis_tready out 1, rx_msgs out 16, rx_err out 1, rx_err_cnt out 16.

## Operation
- The generator state machine has four states: IDLE, HDR, PAYLOAD, GAP.
- IDLE → HDR on start.
  - All configuration inputs are latched at this point.
  - payload_words = 0 is treated as 1; values above PAYLOAD_MAX_WORDS are clipped to PAYLOAD_MAX_WORDS.
  - msgs_sent, the destination index and the pattern counter are cleared.
- HDR drives the header word.
  - Header = {rx_uid_base + dest_idx (8-bit wrap), tx_uid, words×4 (16 bits)}.
  - dest_idx runs 0..NUM_DEST-1 and wraps.
  - On handshake → PAYLOAD.
- PAYLOAD drives the payload words.
  - The pattern counter increments per accepted payload beat and continues across messages; it is not reset per message.
  - m_axis_tlast is asserted on the last word.
  - On the tlast handshake: msgs_sent++ and dest_idx advances.
- After the tlast handshake, the next state is:
  - IDLE if stop has been seen or msgs_sent reaches num_msgs (num_msgs ≠ 0); done pulses.
  - GAP if gap_cycles > 0.
  - HDR otherwise.
- GAP holds m_axis_tvalid low for exactly gap_cycles cycles, then → HDR.
- stop is latched as a sticky request.
  - A message in progress is always completed; messages are never truncated.
  - stop in GAP → IDLE at the next cycle, with a done pulse.
- start while busy is ignored.
- busy = 1 in every state except IDLE.
- AXI rules: tdata and tlast are held stable while tvalid=1 and tready=0; tvalid never drops without a handshake.
- msgs_sent saturates at 16'hFFFF in continuous mode.
- Checker (rx side):
  - s_axis_tready is tied to 1 after reset.
  - The first beat of each message is the header. Payload beats are counted until tlast.
  - At tlast: rx_msgs++. If count×4 ≠ the header LEN field, rx_err is set (sticky until reset) and rx_err_cnt++ (saturating).
  - A header beat carrying tlast is an error unless LEN = 0.

## Timing
- Reset values: m_axis_tdata=0, tlast=0, tvalid=0, busy=0, done=0, msgs_sent=0, rx_msgs=0, rx_err=0, rx_err_cnt=0, s_axis_tready=0 (rises the cycle after reset release).
- start sampled at edge N → tvalid=1 with the header from edge N+1.
- With tready held 1, one message occupies 1+words consecutive cycles.
- Gap measured from the tlast-handshake edge: the next header appears gap_cycles+1 edges later.
- done asserts the cycle after the final tlast handshake; busy falls in that same cycle.
- All outputs are registered; there is no combinational path from tready to tvalid.
- Reset mid-message clears every register immediately; no tlast is emitted.

## Configuration
- TRAFGEN_CHECKER_EN defined: the checker logic and ports are present.
- TRAFGEN_CHECKER_EN undefined: the checker ports are absent and the block is generator-only, with an identical generator cycle behaviour.

## Test plan
- num_msgs=1, payload_words=216, tx_uid=1, rx_uid_base=2, mode 0, tready=1 → header 32'h02010360, then 216 × 32'h00000001 with tlast on word 216; done 1 cycle later; msgs_sent=1.
- num_msgs=5, NUM_DEST=4, rx_uid_base=8'hFE → header UIDs FE, FF, 00, 01, FE (8-bit wrap).
- pattern_mode=1, payload_words=3, num_msgs=2, gap_cycles=4 → payload 0,1,2 | 4 idle cycles | 3,4,5.
- Random tready back-pressure on 100 messages → tdata/tlast stable during stalls; loopback checker gives rx_msgs=100, rx_err=0.
- Checker fed a header with LEN=12 but 2 payload beats → rx_err=1, rx_err_cnt=1; a following good message leaves rx_err=1 and rx_err_cnt unchanged.
- num_msgs=0 with stop pulsed mid-payload → current message completes with tlast, done pulses, no further header; reset asserted mid-message → all outputs return to reset values asynchronously.
